byteop_arb: RTL and testbench
=============================

# byteop_arb

Two-requester arbiter and result-staging controller for the shared bitmanip byte-operation unit (rev8 / orc.b). It lets the integer execute pipe (requester 0) and an auxiliary unit (requester 1, e.g. crypto/scalar-K sequencer) share one `byteop` datapath. It uses valid/ready handshakes on both requests and on the single result channel. A one-entry registered output stage gives one-cycle latency and full throughput under continuous `ResultReady`.

## Interface
- `WIDTH`, default 32: operand/result width in bits (XLEN); multiple of 8.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `Req0Valid`  in  1: requester 0 has an operation.
- `Req0Ready`  out  1: requester 0's operation accepted this cycle.
- `Req0A`  in  WIDTH: requester 0 operand.
- `Req0Sel`  in  1: requester 0 op select; 0 = rev8, 1 = orc.b.
- `Req1Valid`, `Req1Ready`, `Req1A`, `Req1Sel`: same as requester 0, for requester 1.
- `Flush`  in  1: integer-pipe flush; kills requester-0 work only.
- `ResultValid`  out  1: staged result is valid.
- `ResultReady`  in  1: consumer takes the result this cycle.
- `Result`  out  WIDTH: byte-op result.
- `ResultId`  out  1: originating requester (0/1).

## Operation
- `CanAccept = ~ResultValid | ResultReady`. The stage accepts at most one request per cycle.
- Arbitration, both valid: grant goes to the requester not equal to `LastGrant`. `LastGrant` updates only on an actual acceptance.
- Arbitration, one valid: that requester is granted.
- `ReqNReady = GrantN & CanAccept`, combinational from inputs. Exactly zero or one Ready is high per cycle.
- Requester rule: once `ReqNValid` rises, it holds and `ReqNA`/`ReqNSel` stay stable until `ReqNReady`. The block may re-pick between requesters each cycle until acceptance.
- On acceptance, the granted operand and select drive the `byteop` datapath. At the clock edge the output stage loads `Result`, `ResultId` and `ResultValid=1`.
- `ResultReady` without a new accept clears `ResultValid` at the next edge.
- `ResultReady` with a new accept in the same cycle replaces the entry back-to-back.
- `Flush`:
  - It clears a staged entry with `ResultId==0` (`ResultValid` goes to 0 next edge).
  - A requester-0 accept in the same cycle is handshaken (`Req0Ready=1`) and dropped.
  - A requester-1 accept or a staged id-1 entry is unaffected.
  - `Flush` does not change `LastGrant`.
- `ResultValid` and `Result` are never modified while the entry is stalled (`ResultValid & ~ResultReady`), except by the `Flush` rule above.

## Timing
- Reset values:
  - `ResultValid=0`, `Result=0`, `ResultId=0`.
  - `LastGrant=1`, so requester 0 wins the first tie.
  - `Req0Ready`/`Req1Ready` are 0 while `reset` is high.
- Latency: acceptance in cycle N gives `ResultValid` in cycle N+1.
- Throughput: 1 op/cycle with `ResultReady` held high. Under sustained contention, grants alternate 0,1,0,1…
- Reset asserted mid-operation drops the staged entry immediately (async). No state survives.
- Back-pressure: with `ResultValid & ~ResultReady`, both Readies are 0.

## Configuration
- `BYTEOP_ARB_RR_EN` defined: round-robin arbitration as above.
- `BYTEOP_ARB_RR_EN` undefined: fixed priority, requester 0 always wins. `LastGrant` is not implemented, and requester 1 can starve. All other behaviour is identical.

## Structure
- The shared bitmanip package holds:
  - the select encoding constants `BYTESEL_REV8=1'b0` and `BYTESEL_ORCB=1'b1`;
  - the requester-id constants `REQ_INT=1'b0` and `REQ_AUX=1'b1`.
- Datapath: instantiate the existing `byteop #(WIDTH)` unit once, fed by a 2:1 operand/select mux on the grant.
- One new sub-module, `byteop_arb_pick`: a 2-way grant picker with inputs valids and `LastGrant`, and one-hot grant as output. It is `ifdef`-selected between round-robin and fixed priority.

## Test plan
- Single op: `Req0A=0x12003400`, `Sel=0`, `ResultReady=1` → next cycle `ResultValid=1`, `Result=0x00340012`, `ResultId=0`. Same operand with `Sel=1` → `0xFF00FF00`.
- Contention: both valid continuously for 4 cycles, `ResultReady=1` → grant order 0,1,0,1 (round-robin). With the macro undefined → 0,0,0,0.
- Back-pressure: `ResultReady=0` with a staged entry → both Readies are 0 and `Result` holds. Raise `ResultReady` with `Req1Valid=1` → the replacement lands the next cycle with no bubble.
- Flush staged entry: id-0 entry staged with `ResultReady=0`, pulse `Flush` → `ResultValid=0` next cycle.
- Flush with an id-1 entry staged → the entry remains.
- Flush on accept: `Req0Valid` and `Flush` in the same cycle → `Req0Ready=1`, and no result appears.
- Async reset mid-stream: assert `reset` with an entry staged → `ResultValid=0` before the next edge. After release, a tie grants requester 0 first.

Source files
------------

// File: rtl/byteop_arb_pkg.sv
// Shared bitmanip constants: byte-op select encodings and requester ids.
// Imported by the byte-op datapath, the grant picker and the arbiter top.
package byteop_arb_pkg;

   localparam logic BYTESEL_REV8 = 1'b0;
   localparam logic BYTESEL_ORCB = 1'b1;

   localparam logic REQ_INT = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   // Requester id -> one-hot grant vector
   function automatic logic [1:0] id_to_grant(input logic id);
      return (id == REQ_AUX) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/byteop.sv
// Bitmanip byte-operation datapath: rev8 (byte reverse) or orc.b (per-byte OR-combine).
// Purely combinational; WIDTH must be a multiple of 8.
module byteop
   import byteop_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   localparam int NBYTES = WIDTH / 8;

   logic [WIDTH-1:0] rev;
   logic [WIDTH-1:0] orc;

   always_comb begin
      rev = '0;
      orc = '0;
      for (int i = 0; i < NBYTES; i++) begin
         rev[8*i +: 8] = a[8*(NBYTES-1-i) +: 8];
         orc[8*i +: 8] = {8{|a[8*i +: 8]}};
      end
   end

   assign y = (sel == BYTESEL_ORCB) ? orc : rev;

endmodule

// File: rtl/byteop_arb_pick.sv
// Two-way grant picker producing a one-hot grant.
// BYTEOP_ARB_RR_EN selects round-robin on last grant; otherwise requester 0 has fixed priority.
module byteop_arb_pick
   import byteop_arb_pkg::*;
(
   input  logic       valid0,
   input  logic       valid1,
`ifdef BYTEOP_ARB_RR_EN
   input  logic       last_grant,
`endif
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (valid0 && valid1) begin
`ifdef BYTEOP_ARB_RR_EN
         // Tie goes to whoever did not win the last accepted op
         grant = id_to_grant(~last_grant);
`else
         grant = id_to_grant(REQ_INT);
`endif
      end else if (valid0) begin
         grant = id_to_grant(REQ_INT);
      end else if (valid1) begin
         grant = id_to_grant(REQ_AUX);
      end
   end

endmodule

// File: rtl/byteop_arb.sv
// Two-requester arbiter with a one-entry registered result stage for the shared byteop unit.
// Define BYTEOP_ARB_RR_EN for round-robin arbitration; default build is fixed priority (req 0).
module byteop_arb
   import byteop_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Req0Valid,
   output logic             Req0Ready,
   input  logic [WIDTH-1:0] Req0A,
   input  logic             Req0Sel,
   input  logic             Req1Valid,
   output logic             Req1Ready,
   input  logic [WIDTH-1:0] Req1A,
   input  logic             Req1Sel,
   input  logic             Flush,
   output logic             ResultValid,
   input  logic             ResultReady,
   output logic [WIDTH-1:0] Result,
   output logic             ResultId
);

   logic [1:0]       grant;
   logic             can_accept;
   logic             accept;
   logic             grant_id;
   logic             drop;
   logic [WIDTH-1:0] op_a;
   logic             op_sel;
   logic [WIDTH-1:0] op_y;

`ifdef BYTEOP_ARB_RR_EN
   logic last_grant;
`endif

   byteop_arb_pick u_pick (
      .valid0     (Req0Valid),
      .valid1     (Req1Valid),
`ifdef BYTEOP_ARB_RR_EN
      .last_grant (last_grant),
`endif
      .grant      (grant)
   );

   assign can_accept = ~ResultValid | ResultReady;
   assign Req0Ready  = grant[0] & can_accept & ~reset;
   assign Req1Ready  = grant[1] & can_accept & ~reset;
   assign accept     = Req0Ready | Req1Ready;
   assign grant_id   = grant[1] ? REQ_AUX : REQ_INT;

   // A flushed requester-0 op is still handshaken, just never staged
   assign drop = Flush & (grant_id == REQ_INT);

   assign op_a   = grant[1] ? Req1A   : Req0A;
   assign op_sel = grant[1] ? Req1Sel : Req0Sel;

   byteop #(
      .WIDTH (WIDTH)
   ) u_byteop (
      .a   (op_a),
      .sel (op_sel),
      .y   (op_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ResultValid <= 1'b0;
         Result      <= '0;
         ResultId    <= REQ_INT;
      end else if (accept && !drop) begin
         ResultValid <= 1'b1;
         Result      <= op_y;
         ResultId    <= grant_id;
      end else if (ResultReady || (Flush && ResultId == REQ_INT)) begin
         ResultValid <= 1'b0;
      end
   end

`ifdef BYTEOP_ARB_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= REQ_AUX;
      end else if (accept) begin
         last_grant <= grant_id;
      end
   end
`endif

endmodule

// File: tb/tb_byteop_arb.sv
// Directed self-checking bench for byteop_arb; expectations follow BYTEOP_ARB_RR_EN.
module tb_byteop_arb;
   import byteop_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        Req0Valid, Req0Ready, Req0Sel;
   logic        Req1Valid, Req1Ready, Req1Sel;
   logic [31:0] Req0A, Req1A;
   logic        Flush;
   logic        ResultValid, ResultReady, ResultId;
   logic [31:0] Result;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   byteop_arb #(
      .WIDTH (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Req0Valid   (Req0Valid),
      .Req0Ready   (Req0Ready),
      .Req0A       (Req0A),
      .Req0Sel     (Req0Sel),
      .Req1Valid   (Req1Valid),
      .Req1Ready   (Req1Ready),
      .Req1A       (Req1A),
      .Req1Sel     (Req1Sel),
      .Flush       (Flush),
      .ResultValid (ResultValid),
      .ResultReady (ResultReady),
      .Result      (Result),
      .ResultId    (ResultId)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic        exp_id [4];
   logic [31:0] exp_res [4];

   initial begin
      reset = 1'b1; Flush = 1'b0; ResultReady = 1'b0;
      Req0Valid = 1'b1; Req0A = 32'h0; Req0Sel = 1'b0;
      Req1Valid = 1'b0; Req1A = 32'h0; Req1Sel = 1'b0;
      #12;
      chk("reset_valid", {31'd0, ResultValid}, 32'd0);
      chk("reset_result", Result, 32'h0);
      chk("reset_id", {31'd0, ResultId}, 32'd0);
      chk("reset_ready0", {31'd0, Req0Ready}, 32'd0);
      Req0Valid = 1'b0;
      #5 reset = 1'b0;
      tick();

      // Contention right after reset: requester 0 wins the first tie
`ifdef BYTEOP_ARB_RR_EN
      exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`else
      exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`endif
      for (int i = 0; i < 4; i++) exp_res[i] = exp_id[i] ? 32'hDDCCBBAA : 32'h44332211;
      Req0Valid = 1'b1; Req0A = 32'h11223344; Req0Sel = BYTESEL_REV8;
      Req1Valid = 1'b1; Req1A = 32'hAABBCCDD; Req1Sel = BYTESEL_REV8;
      ResultReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("cont_ready0_%0d", i), {31'd0, Req0Ready}, {31'd0, ~exp_id[i]});
         chk($sformatf("cont_ready1_%0d", i), {31'd0, Req1Ready}, {31'd0, exp_id[i]});
         tick();
         chk($sformatf("cont_id_%0d", i), {31'd0, ResultId}, {31'd0, exp_id[i]});
         chk($sformatf("cont_res_%0d", i), Result, exp_res[i]);
      end
      Req0Valid = 1'b0; Req1Valid = 1'b0;
      tick();

      // Single op: rev8 then orc.b on the same operand
      Req0Valid = 1'b1; Req0A = 32'h12003400; Req0Sel = BYTESEL_REV8;
      tick();
      chk("single_valid", {31'd0, ResultValid}, 32'd1);
      chk("single_rev8", Result, 32'h00340012);
      chk("single_id", {31'd0, ResultId}, 32'd0);
      Req0Sel = BYTESEL_ORCB;
      tick();
      chk("single_orcb", Result, 32'hFF00FF00);

      // Back-pressure: staged id-0 entry stalls, then replaced by req 1 without a bubble
      Req0Valid = 1'b0; ResultReady = 1'b0;
      Req1Valid = 1'b1; Req1A = 32'h00000080; Req1Sel = BYTESEL_ORCB;
      #2;
      chk("bp_ready0", {31'd0, Req0Ready}, 32'd0);
      chk("bp_ready1", {31'd0, Req1Ready}, 32'd0);
      tick();
      chk("bp_hold_valid", {31'd0, ResultValid}, 32'd1);
      chk("bp_hold_result", Result, 32'hFF00FF00);
      ResultReady = 1'b1;
      #2;
      chk("bp_release_ready1", {31'd0, Req1Ready}, 32'd1);
      tick();
      chk("bp_repl_valid", {31'd0, ResultValid}, 32'd1);
      chk("bp_repl_result", Result, 32'h000000FF);
      chk("bp_repl_id", {31'd0, ResultId}, 32'd1);
      Req1Valid = 1'b0; ResultReady = 1'b0;

      // Flush leaves a staged id-1 entry alone
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("flush_id1_valid", {31'd0, ResultValid}, 32'd1);
      chk("flush_id1_result", Result, 32'h000000FF);

      // Flush kills a staged id-0 entry
      ResultReady = 1'b1;
      Req0Valid = 1'b1; Req0A = 32'h01020304; Req0Sel = BYTESEL_REV8;
      tick();
      Req0Valid = 1'b0; ResultReady = 1'b0;
      chk("flush_id0_staged", Result, 32'h04030201);
      chk("flush_id0_staged_id", {31'd0, ResultId}, 32'd0);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("flush_id0_valid", {31'd0, ResultValid}, 32'd0);

      // Flush on a requester-0 accept: handshaken, never staged
      Req0Valid = 1'b1; Req0A = 32'h55000000; Flush = 1'b1; ResultReady = 1'b1;
      #2;
      chk("flush_acc_ready0", {31'd0, Req0Ready}, 32'd1);
      tick();
      Req0Valid = 1'b0; Flush = 1'b0;
      chk("flush_acc_valid", {31'd0, ResultValid}, 32'd0);

      // Async reset mid-stream, then a tie goes to requester 0
      Req1Valid = 1'b1; Req1A = 32'h00FF0000; Req1Sel = BYTESEL_REV8;
      tick();
      chk("ar_staged_valid", {31'd0, ResultValid}, 32'd1);
      chk("ar_staged_result", Result, 32'h0000FF00);
      Req1Valid = 1'b0; ResultReady = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("ar_async_valid", {31'd0, ResultValid}, 32'd0);
      chk("ar_async_result", Result, 32'h0);
      #1 reset = 1'b0;
      Req0Valid = 1'b1; Req0A = 32'h0000AB00; Req0Sel = BYTESEL_ORCB;
      Req1Valid = 1'b1; ResultReady = 1'b1;
      #1;
      chk("ar_tie_ready0", {31'd0, Req0Ready}, 32'd1);
      chk("ar_tie_ready1", {31'd0, Req1Ready}, 32'd0);
      tick();
      chk("ar_tie_id", {31'd0, ResultId}, 32'd0);
      chk("ar_tie_result", Result, 32'h0000FF00);
      Req0Valid = 1'b0; Req1Valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
